// File: rtl/sqrt_reconstruct.sv
// sqrt_reconstruct: rebuilds the radicand Q*Q+R from an integer square-root
// result (quotient Q, remainder R) with a W-cycle shift-and-add multiplier.
// Also flags whether R is a legal remainder and whether the low half is zero.
module sqrt_reconstruct #(
    parameter int W = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   IN_Q,
    input  logic [W-1:0]   IN_R,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] OUT,
    output logic           rem_ok,
    output logic           frac_zero
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  acc;
    logic [W-1:0]    mcand;
    logic [W-1:0]    mplier;
    logic            rem_ok_r;

    // Multiplicand weighted by the current bit position, widened to the
    // accumulator width. The sum Q*Q+R always fits in 2W bits, so no carry
    // out of the accumulator is needed.
    function automatic logic [2*W-1:0] partial_term(input logic [W-1:0] m,
                                                    input logic [CW-1:0] sh);
        logic [2*W-1:0] wide;
        wide = {{W{1'b0}}, m};
        return wide << sh;
    endfunction

    // A remainder is legal for integer sqrt when R <= 2Q; compared at W+1 bits
    // so 2Q cannot wrap.
    function automatic logic legal_rem(input logic [W-1:0] q,
                                       input logic [W-1:0] r);
        return ({1'b0, r} <= {q, 1'b0});
    endfunction

    // Control FSM and shift-and-add datapath; reset wins over every update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem_ok_r <= 1'b0;
        end else begin
            case (state)
                // accept: capture operands, seed accumulator with R
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= IN_Q;
                        mplier   <= IN_Q;
                        acc      <= {{W{1'b0}}, IN_R};
                        cnt      <= '0;
                        rem_ok_r <= legal_rem(IN_Q, IN_R);
                        state    <= CALC;
                    end
                end
                // one multiplier bit per cycle, fixed W cycles even for Q == 0
                CALC: begin
                    if (mplier[0]) begin
                        acc <= acc + partial_term(mcand, cnt);
                    end
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                // hold result until the consumer takes it
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign OUT       = acc;
    assign rem_ok    = rem_ok_r;
    assign frac_zero = (acc[W-1:0] == '0);

endmodule

// File: tb/tb_sqrt_reconstruct.sv
// Bench for sqrt_reconstruct: directed corners, backpressure, mid-op reset
// and randomized operands checked against a plain-arithmetic model.
module tb_sqrt_reconstruct;

    localparam int W = 24;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   IN_Q;
    logic [W-1:0]   IN_R;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] OUT;
    logic           rem_ok;
    logic           frac_zero;

    int tests;
    int fails;

    sqrt_reconstruct #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .IN_Q      (IN_Q),
        .IN_R      (IN_R),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .OUT       (OUT),
        .rem_ok    (rem_ok),
        .frac_zero (frac_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: radicand = Q*Q + R in 64-bit arithmetic.
    function automatic logic [63:0] model_out(input logic [W-1:0] q,
                                              input logic [W-1:0] r);
        logic [63:0] qq;
        qq = 64'(q);
        return qq * qq + 64'(r);
    endfunction

    function automatic logic model_rem_ok(input logic [W-1:0] q,
                                          input logic [W-1:0] r);
        return 64'(r) <= 64'(q) * 2;
    endfunction

    function automatic logic model_frac_zero(input logic [63:0] v);
        return (v % (64'd1 << W)) == 0;
    endfunction

    // One full transaction: accept, count latency, hold in DONE, handshake.
    task automatic do_op(input logic [W-1:0] q, input logic [W-1:0] r,
                         input int hold, input string tag);
        logic [63:0] e;
        int k;
        e = model_out(q, r);
        @(negedge clk);
        check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        IN_Q = q;
        IN_R = r;
        @(posedge clk);
        @(negedge clk);
        // garbage on inputs during CALC must be ignored
        IN_Q = W'($urandom);
        IN_R = W'($urandom);
        k = 0;
        while (!out_valid && k < 100) begin
            check({tag, ".in_ready_calc"}, 64'(in_ready), 64'd0);
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        check({tag, ".latency"}, 64'(k), 64'(W));
        check({tag, ".out"}, 64'(OUT), e);
        check({tag, ".rem_ok"}, 64'(rem_ok), 64'(model_rem_ok(q, r)));
        check({tag, ".frac_zero"}, 64'(frac_zero), 64'(model_frac_zero(e)));
        check({tag, ".in_ready_done"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".hold_out"}, 64'(OUT), e);
            check({tag, ".hold_rem_ok"}, 64'(rem_ok), 64'(model_rem_ok(q, r)));
            check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".valid_after_hs"}, 64'(out_valid), 64'd0);
        check({tag, ".ready_after_hs"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int k;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        IN_Q = '0;
        IN_R = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.out", 64'(OUT), 64'd0);
        check("rst.rem_ok", 64'(rem_ok), 64'd0);
        check("rst.frac_zero", 64'(frac_zero), 64'd1);

        // reset beats acceptance on the same edge
        in_valid = 1'b1;
        IN_Q = 24'd9;
        IN_R = 24'd1;
        @(negedge clk);
        check("rst_prio.in_ready", 64'(in_ready), 64'd1);
        check("rst_prio.out", 64'(OUT), 64'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // directed corners
        do_op(24'h000000, 24'h000000, 0, "zero");
        do_op(24'h800000, 24'h000000, 0, "half");
        do_op(24'hFFFFFF, 24'hFFFFFF, 0, "max");
        do_op(24'd3, 24'd7, 0, "q3r7");

        // backpressure for 10 cycles
        do_op(24'h123456, 24'h000ABC, 10, "bp");

        // reset mid-CALC
        @(negedge clk);
        in_valid = 1'b1;
        IN_Q = 24'hABCDEF;
        IN_R = 24'h000123;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst.in_ready", 64'(in_ready), 64'd1);
        check("midrst.out_valid", 64'(out_valid), 64'd0);
        check("midrst.out", 64'(OUT), 64'd0);
        check("midrst.rem_ok", 64'(rem_ok), 64'd0);
        k = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) k++;
        end
        check("midrst.no_valid", 64'(k), 64'd0);
        do_op(24'd5, 24'd2, 0, "after_rst");

        // reset while in DONE aborts the result
        @(negedge clk);
        in_valid = 1'b1;
        IN_Q = 24'd100;
        IN_R = 24'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("donerst.reached", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("donerst.out_valid", 64'(out_valid), 64'd0);
        check("donerst.in_ready", 64'(in_ready), 64'd1);

        // randomized operands, mix of legal and illegal remainders
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] q;
            logic [W-1:0] r;
            q = W'($urandom);
            if (i % 2 == 0) r = W'($urandom_range(0, 1000)) % (W'(q) + W'(1));
            else r = W'($urandom);
            do_op(q, r, $urandom_range(0, 3), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sqrt_reconstruct.md
SQRT_RECONSTRUCT -- requirements
Module: sqrt_reconstruct

Interface
REQ-001 The block SHALL have parameter W, default 24, giving the root and remainder width; the result width is 2W.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 Port in_valid, input, 1 bit: IN_Q and IN_R hold a request.
REQ-005 Port in_ready, output, 1 bit: block can accept a request.
REQ-006 Port IN_Q, input, W bits: square-root quotient Q, unsigned.
REQ-007 Port IN_R, input, W bits: remainder R, unsigned.
REQ-008 Port out_valid, output, 1 bit: OUT, rem_ok and frac_zero hold a result.
REQ-009 Port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 Port OUT, output, 2W bits: reconstructed radicand Q*Q+R.
REQ-011 Port rem_ok, output, 1 bit: 1 when R <= 2*Q, meaning a legal integer-sqrt remainder.
REQ-012 Port frac_zero, output, 1 bit: 1 when OUT[W-1:0] == 0, meaning the radicand had a zero low half (mantissa<<W form).

Function
REQ-013 The block SHALL implement the FSM states IDLE, CALC and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 Acceptance SHALL occur on an edge with IDLE && in_valid; on that edge the block SHALL:
- latch Q into a multiplicand register;
- latch Q into a multiplier shift register;
- load the 2W-bit accumulator with zero-extended R;
- clear the bit counter;
- go to CALC.
REQ-016 On each edge in CALC, the block SHALL add (multiplicand << counter) to the accumulator, zero-extended to 2W bits, if the multiplier LSB is 1, then shift the multiplier right 1 and increment the counter.
REQ-017 After the W-th CALC edge (counter reaching W-1 and processed), the state SHALL become DONE; out_valid therefore rises exactly W edges after acceptance (24 for the default).
REQ-018 The arithmetic SHALL be unsigned and 2W bits wide, and SHALL never overflow, since (2^W-1)^2 + (2^W-1) < 2^(2W); no carry-out is kept.
REQ-019 rem_ok SHALL be computed at acceptance as R <= {Q,1'b0} using W+1-bit compare, registered, and held through DONE.
REQ-020 frac_zero SHALL be combinational from the accumulator low W bits, and SHALL be valid whenever out_valid is 1.
REQ-021 In DONE, OUT, rem_ok and frac_zero SHALL stay stable while out_valid && !out_ready.
REQ-022 DONE && out_ready SHALL return the state to IDLE on that edge.
REQ-023 in_ready SHALL be 0 in the DONE cycle, so there is one bubble cycle between back-to-back operations.
REQ-024 in_valid while not IDLE SHALL be ignored, and IN_Q/IN_R changes after acceptance SHALL not affect the result.
REQ-025 Q == 0 SHALL still take W CALC cycles (fixed latency, no early exit).
REQ-026 OUT SHALL be driven from the accumulator at all times; its value outside DONE is don't-care for the consumer but SHALL be deterministic.

Reset
REQ-027 When rst_n == 0 at a rising edge, the block SHALL set state=IDLE, counter=0, accumulator=0, multiplicand=0, multiplier=0 and rem_ok=0.
REQ-028 The output values in the cycle after reset SHALL be in_ready=1, out_valid=0, OUT=0, rem_ok=0 and frac_zero=1.
REQ-029 Reset SHALL take priority over every other event, including acceptance and CALC updates in the same cycle.
REQ-030 Reset asserted mid-CALC or in DONE SHALL abort the operation, and no out_valid SHALL be produced for it.
REQ-031 The block SHALL have no asynchronous reset path.

Verification
REQ-032 Q=0x000000, R=0x000000 -> after 24 cycles out_valid=1, OUT=0x000000000000, rem_ok=1, frac_zero=1.
REQ-033 Q=0x800000, R=0 -> OUT=0x400000000000, rem_ok=1, frac_zero=1.
REQ-034 Q=0xFFFFFF, R=0xFFFFFF -> OUT=0xFFFFFF000000, rem_ok=1, frac_zero=1 (max-operand corner).
REQ-035 Q=3, R=7 -> OUT=0x000000000010, rem_ok=0, frac_zero=0.
REQ-036 Backpressure: hold out_ready=0 for 10 cycles in DONE -> OUT stable and in_ready=0 throughout; the next request is accepted no earlier than one cycle after the out_ready handshake.
REQ-037 Reset mid-op: assert rst_n=0 at CALC cycle 12 -> next cycle state IDLE, in_ready=1, out_valid=0, OUT=0; a following request (Q=5, R=2) -> OUT=27.
